// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle 16x16 -> 16 shift-and-add multiplier that uses one
// Hack alu as its only adder. It alternates ADD (acc += mcand when the current
// multiplier bit is set) and DBL (mcand += mcand) for each multiplier bit.
// Optional build macro: ALU_MUL_EARLY_EXIT_EN. When it is defined, the block
// finishes as soon as no multiplier bits remain. The product is the same in
// both builds; only the latency changes.

// Hack alu: conditional zero/negate of each input, then add or AND, then an
// optional negate of the result.
module hack_alu (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        zx_i,
    input  logic        nx_i,
    input  logic        zy_i,
    input  logic        ny_i,
    input  logic        f_i,
    input  logic        no_i,
    output logic [15:0] out_o,
    output logic        zr_o,
    output logic        ng_o
);
    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    // Pure combinational alu datapath
    always_comb begin
        x_z   = zx_i ? 16'h0000 : x_i;
        x_n   = nx_i ? ~x_z : x_z;
        y_z   = zy_i ? 16'h0000 : y_i;
        y_n   = ny_i ? ~y_z : y_z;
        f_out = f_i ? (x_n + y_n) : (x_n & y_n);
        out_o = no_i ? ~f_out : f_out;
        zr_o  = (out_o == 16'h0000);
        ng_o  = out_o[15];
    end
endmodule

module alu_mul_seq #(
    parameter int ITERS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic        alu_zr, alu_ng;

    hack_alu u_alu (
        .x_i   (alu_x),
        .y_i   (alu_y),
        .zx_i  (alu_zx),
        .nx_i  (alu_nx),
        .zy_i  (alu_zy),
        .ny_i  (alu_ny),
        .f_i   (alu_f),
        .no_i  (alu_no),
        .out_o (alu_out),
        .zr_o  (alu_zr),
        .ng_o  (alu_ng)
    );

    // Next-state logic, alu control steering and handshake outputs
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        // Idle control forces alu.out to zero (0 & 0)
        alu_x     = 16'h0000;
        alu_y     = 16'h0000;
        alu_zx    = 1'b1;
        alu_nx    = 1'b0;
        alu_zy    = 1'b1;
        alu_ny    = 1'b0;
        alu_f     = 1'b0;
        alu_no    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        product   = 16'h0000;
        zr        = alu_zr;
        ng        = alu_ng;

        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    acc_d    = 16'h0000;
                    mcand_d  = a;
                    mplier_d = b;
                    cnt_d    = 4'd0;
`ifdef ALU_MUL_EARLY_EXIT_EN
                    state_d  = (b == 16'h0000) ? DONE : ADD;
`else
                    state_d  = ADD;
`endif
                end
            end
            ADD: begin
                alu_x  = acc_q;
                alu_y  = mcand_q;
                alu_zx = 1'b0;
                alu_zy = 1'b0;
                alu_f  = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = alu_out;
                end
                state_d = DBL;
            end
            DBL: begin
                alu_x    = mcand_q;
                alu_y    = mcand_q;
                alu_zx   = 1'b0;
                alu_zy   = 1'b0;
                alu_f    = 1'b1;
                mcand_d  = alu_out;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
`ifdef ALU_MUL_EARLY_EXIT_EN
                if ((cnt_q == 4'(ITERS - 1)) || ((mplier_q >> 1) == 16'h0000)) begin
                    state_d = DONE;
                end else begin
                    state_d = ADD;
                end
`else
                state_d  = (cnt_q == 4'(ITERS - 1)) ? DONE : ADD;
`endif
            end
            DONE: begin
                // acc + 0 passes the accumulator through so the flags come from the alu
                alu_x     = acc_q;
                alu_zx    = 1'b0;
                alu_zy    = 1'b1;
                alu_f     = 1'b1;
                out_valid = 1'b1;
                product   = alu_out;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: directed cases followed by random operands,
// checked against a reference product computed with plain wide multiplication.
module tb_alu_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        zr;
    logic        ng;

    int tests = 0;
    int fails = 0;

    alu_mul_seq #(.ITERS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .zr        (zr),
        .ng        (ng)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Highest set bit index of v, or -1 when v is zero
    function automatic int msb_index(input logic [15:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < 16; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    // One full transaction: wait for in_ready, accept, wait for the result,
    // hold backpressure for 'hold' cycles (0 = out_ready already high), release.
    task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                          input int hold);
        logic [31:0] full;
        logic [15:0] exp_p;
        int          guard;
        int          lat;
        int          exp_lat;

        full  = {16'h0000, op_a} * {16'h0000, op_b};
        exp_p = full[15:0];

        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);

        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = op_a;
        b         = op_b;
        step();
        in_valid  = 1'b0;
        a         = 16'($urandom);
        b         = 16'($urandom);

        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
`ifdef ALU_MUL_EARLY_EXIT_EN
        exp_lat = (op_b == 16'h0000) ? 0 : 2 * (msb_index(op_b) + 1);
        check({tag, "_latency_bound"}, 32'(lat <= 32), 32'd1);
        if (op_b != 16'h0000) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
`else
        exp_lat = 32;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
`endif
        check({tag, "_product"}, 32'(product), 32'(exp_p));
        check({tag, "_zr"}, 32'(zr), 32'(exp_p == 16'h0000));
        check({tag, "_ng"}, 32'(ng), 32'(exp_p[15]));
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);

        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_product"}, 32'(product), 32'(exp_p));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_released_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_released_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;

        // Reset state
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op("mul_3x5", 16'd3, 16'd5, 0);
        run_op("wrap_0100sq", 16'h0100, 16'h0100, 0);
        run_op("neg3x7", 16'hFFFD, 16'd7, 0);
        run_op("neg1xneg1", 16'hFFFF, 16'hFFFF, 0);
        run_op("bp_6x7", 16'd6, 16'd7, 5);
        run_op("b_zero", 16'h1234, 16'h0000, 0);
        run_op("b_one", 16'h1234, 16'h0001, 1);
        run_op("b_msb", 16'h0001, 16'h8000, 0);

        // Reset in the middle of an operation
        in_valid = 1'b1;
        a        = 16'd9;
        b        = 16'd9;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("midop_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midop_rst_low_in_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("midop_out_valid", 32'(out_valid), 32'd0);
        check("midop_in_ready", 32'(in_ready), 32'd1);
        run_op("after_rst_2x3", 16'd2, 16'd3, 0);

        // Random operands with random backpressure
        for (int n = 0; n < 20; n++) begin
            run_op("rand", 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
